// File: rtl/usb_buffer_pkg.sv
// Shared types and width helpers for the USB receive packet buffer.
package usb_buffer_pkg;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_STORE   = 2'd1,
    RX_DISCARD = 2'd2
  } rx_state_t;

  // One extra bit beyond the address distinguishes full from empty.
  function automatic int ptr_width(input int entries);
    return $clog2(entries) + 1;
  endfunction

  // Wide enough to hold a length equal to the full byte depth.
  function automatic int len_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/usb_pkt_len_fifo.sv
// Synchronous FIFO of committed packet lengths; head entry is visible combinationally.
module usb_pkt_len_fifo
  import usb_buffer_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int WIDTH   = 7
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic [WIDTH-1:0]               i_data,
  output logic [WIDTH-1:0]               o_data,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [ptr_width(ENTRIES)-1:0]  o_count
);

  localparam int PW = ptr_width(ENTRIES);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] r_mem [ENTRIES];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_full  = (o_count == PW'(ENTRIES));
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/usb_rx_packet_buffer.sv
// Packet-aware receive buffer: speculative byte writes, commit on good last byte,
// rollback otherwise; FWFT read side only ever exposes committed packets.
module usb_rx_packet_buffer
  import usb_buffer_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int MAX_PACKETS = 4,
  parameter int CNT_W       = 8
) (
  input  logic                          clk48,
  input  logic                          rst,
  output logic                          rxAcceptNewData,
  input  logic [7:0]                    rxData,
  input  logic                          rxIsLastByte,
  input  logic                          rxDataValid,
  input  logic                          keepPacket,
  output logic [7:0]                    outData,
  output logic                          outDataValid,
  output logic                          outIsLastByte,
  input  logic                          outAcceptNewData,
  output logic [$clog2(MAX_PACKETS):0]  packetCount,
  output logic [CNT_W-1:0]              droppedCount
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int LEN_W = len_width(DEPTH);
  localparam int AW    = PTR_W - 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_cmt_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_rd_cnt;
  logic             r_acc;
  logic [7:0]       r_out_data;
  logic             r_out_vld;
  logic [CNT_W-1:0] r_dropped;
  rx_state_t        r_state;
  rx_state_t        w_state_nxt;

  logic             w_hs;
  logic [PTR_W-1:0] w_used;
  logic             w_full;
  logic             w_wr;
  logic             w_commit;
  logic             w_drop;
  logic [LEN_W-1:0] w_len;
  logic [LEN_W-1:0] w_head_len;
  logic [LEN_W-1:0] w_rem;
  logic             w_len_full;
  logic             w_len_empty;
  logic             w_take;
  logic             w_fetch;
  logic             w_last;
  logic             w_pop;

  assign w_hs   = rxDataValid && r_acc;
  assign w_used = r_wr_ptr - r_rd_ptr;
  assign w_full = (w_used == PTR_W'(DEPTH));
  assign w_len  = r_wr_ptr + 1'b1 - r_cmt_ptr;

  // Write-side FSM: a packet that loses a byte to overflow is marked for discard.
  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_commit    = 1'b0;
    w_drop      = 1'b0;
    if (w_hs) begin
      w_wr = (r_state != RX_DISCARD) && !w_full;
      if (rxIsLastByte) begin
        w_commit    = w_wr && keepPacket && !w_len_full;
        w_drop      = !w_commit;
        w_state_nxt = RX_IDLE;
      end else if (r_state != RX_DISCARD) begin
        w_state_nxt = w_full ? RX_DISCARD : RX_STORE;
      end
    end
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      r_state   <= RX_IDLE;
      r_acc     <= 1'b0;
      r_wr_ptr  <= '0;
      r_cmt_ptr <= '0;
      r_dropped <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= 1'b1;
      if (w_commit) begin
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_cmt_ptr <= r_wr_ptr + 1'b1;
      end else if (w_drop) begin
        r_wr_ptr  <= r_cmt_ptr;
        r_dropped <= sat_inc(r_dropped);
      end else if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk48) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= rxData;
  end

  usb_pkt_len_fifo #(
    .ENTRIES (MAX_PACKETS),
    .WIDTH   (LEN_W)
  ) u_len_fifo (
    .i_clk   (clk48),
    .i_rst   (rst),
    .i_push  (w_commit),
    .i_pop   (w_pop),
    .i_data  (w_len),
    .o_data  (w_head_len),
    .o_full  (w_len_full),
    .o_empty (w_len_empty),
    .o_count (packetCount)
  );

  // Read side: the output register is refilled whenever it is empty or being drained.
  assign w_take  = r_out_vld && outAcceptNewData;
  assign w_fetch = (r_cmt_ptr != r_rd_ptr) && (!r_out_vld || w_take);
  assign w_rem   = w_head_len - r_rd_cnt;
  assign w_last  = r_out_vld && !w_len_empty && (w_rem == LEN_W'(1));
  assign w_pop   = w_take && w_last;

  always_ff @(posedge clk48) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_rd_cnt   <= '0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
    end else begin
      if (w_fetch) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_out_data <= r_mem[r_rd_ptr[AW-1:0]];
        r_out_vld  <= 1'b1;
      end else if (w_take) begin
        r_out_vld <= 1'b0;
      end
      if (w_pop)       r_rd_cnt <= '0;
      else if (w_take) r_rd_cnt <= r_rd_cnt + 1'b1;
    end
  end

  assign rxAcceptNewData = r_acc;
  assign outData         = r_out_data;
  assign outDataValid    = r_out_vld;
  assign outIsLastByte   = w_last;
  assign droppedCount    = r_dropped;

endmodule

// File: tb/tb_usb_rx_packet_buffer.sv
// Directed bench for usb_rx_packet_buffer (DEPTH=8, MAX_PACKETS=4, CNT_W=8).
module tb_usb_rx_packet_buffer;

  logic       clk48 = 1'b0;
  logic       rst = 1'b1;
  logic       rxAcceptNewData;
  logic [7:0] rxData = '0;
  logic       rxIsLastByte = 1'b0;
  logic       rxDataValid = 1'b0;
  logic       keepPacket = 1'b0;
  logic [7:0] outData;
  logic       outDataValid;
  logic       outIsLastByte;
  logic       outAcceptNewData = 1'b0;
  logic [2:0] packetCount;
  logic [7:0] droppedCount;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int k       = 0;

  usb_rx_packet_buffer #(
    .DEPTH       (8),
    .MAX_PACKETS (4),
    .CNT_W       (8)
  ) dut (
    .clk48            (clk48),
    .rst              (rst),
    .rxAcceptNewData  (rxAcceptNewData),
    .rxData           (rxData),
    .rxIsLastByte     (rxIsLastByte),
    .rxDataValid      (rxDataValid),
    .keepPacket       (keepPacket),
    .outData          (outData),
    .outDataValid     (outDataValid),
    .outIsLastByte    (outIsLastByte),
    .outAcceptNewData (outAcceptNewData),
    .packetCount      (packetCount),
    .droppedCount     (droppedCount)
  );

  always #5 clk48 = ~clk48;

  task automatic tick();
    @(posedge clk48);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic keep);
    rxData       = d;
    rxIsLastByte = last;
    keepPacket   = keep;
    rxDataValid  = 1'b1;
    tick();
    rxDataValid  = 1'b0;
    rxIsLastByte = 1'b0;
  endtask

  task automatic read_byte(input string tag, input logic [7:0] d, input logic last);
    int w = 0;
    while (!outDataValid && w < 20) begin
      tick();
      w++;
    end
    chk({tag, " vld"}, 32'(outDataValid), 32'h1);
    chk({tag, " data"}, 32'(outData), 32'(d));
    chk({tag, " last"}, 32'(outIsLastByte), 32'(last));
    outAcceptNewData = 1'b1;
    tick();
    outAcceptNewData = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " rxAccept"}, 32'(rxAcceptNewData), 32'h0);
    chk({tag, " outValid"}, 32'(outDataValid), 32'h0);
    chk({tag, " outLast"}, 32'(outIsLastByte), 32'h0);
    chk({tag, " outData"}, 32'(outData), 32'h0);
    chk({tag, " pktCount"}, 32'(packetCount), 32'h0);
    chk({tag, " dropped"}, 32'(droppedCount), 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rxDataValid = 1'b0;
    outAcceptNewData = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    chk("accept after reset", 32'(rxAcceptNewData), 32'h1);

    // Single good packet, latency and hold-while-stalled
    send_byte(8'hC3, 1'b0, 1'b1);
    send_byte(8'h11, 1'b0, 1'b1);
    send_byte(8'h22, 1'b1, 1'b1);
    chk("t1 vld at N+1", 32'(outDataValid), 32'h0);
    chk("t1 pktCount 1", 32'(packetCount), 32'h1);
    tick();
    chk("t1 vld at N+2", 32'(outDataValid), 32'h1);
    chk("t1 first data", 32'(outData), 32'hC3);
    tick();
    chk("t1 hold vld", 32'(outDataValid), 32'h1);
    chk("t1 hold data", 32'(outData), 32'hC3);
    chk("t1 hold last", 32'(outIsLastByte), 32'h0);
    read_byte("t1 b0", 8'hC3, 1'b0);
    read_byte("t1 b1", 8'h11, 1'b0);
    read_byte("t1 b2", 8'h22, 1'b1);
    chk("t1 pktCount 0", 32'(packetCount), 32'h0);
    chk("t1 drained", 32'(outDataValid), 32'h0);

    // Bad packet rolled back, then a good one
    for (int i = 0; i < 5; i++) send_byte(8'(8'hF0 + i), i == 4, 1'b0);
    send_byte(8'h69, 1'b0, 1'b1);
    send_byte(8'h05, 1'b1, 1'b1);
    chk("t2 dropped", 32'(droppedCount), 32'h1);
    read_byte("t2 b0", 8'h69, 1'b0);
    read_byte("t2 b1", 8'h05, 1'b1);
    repeat (3) tick();
    chk("t2 nothing more", 32'(outDataValid), 32'h0);

    // Overflow: 10-byte packet into 8-byte storage, then an exactly-full packet
    for (int i = 0; i < 10; i++) send_byte(8'(8'hA0 + i), i == 9, 1'b1);
    repeat (4) tick();
    chk("t3 overflow no output", 32'(outDataValid), 32'h0);
    chk("t3 overflow dropped", 32'(droppedCount), 32'h2);
    chk("t3 overflow pktCount", 32'(packetCount), 32'h0);
    for (int i = 0; i < 8; i++) send_byte(8'(8'hB0 + i), i == 7, 1'b1);
    chk("t3 full pkt count", 32'(packetCount), 32'h1);
    for (int i = 0; i < 8; i++) read_byte("t3 full pkt", 8'(8'hB0 + i), i == 7);
    chk("t3 dropped unchanged", 32'(droppedCount), 32'h2);

    // Length queue full with consumer stalled
    for (int i = 0; i < 5; i++) send_byte(8'(8'hD0 + i), 1'b1, 1'b1);
    repeat (2) tick();
    chk("t4 pktCount 4", 32'(packetCount), 32'h4);
    chk("t4 dropped", 32'(droppedCount), 32'h3);
    for (int i = 0; i < 4; i++) read_byte("t4 drain", 8'(8'hD0 + i), 1'b1);
    chk("t4 pktCount 0", 32'(packetCount), 32'h0);
    repeat (3) tick();
    chk("t4 fifth absent", 32'(outDataValid), 32'h0);

    // Concurrent streaming with a toggling consumer
    do_reset();
    chk("t5 dropped cleared", 32'(droppedCount), 32'h0);
    k = 0;
    fork
      begin
        for (int p = 0; p < 20; p++) begin
          for (int b = 0; b < 2; b++) send_byte(8'(8'h30 + 2 * p + b), b == 1, 1'b1);
          repeat (3) tick();
        end
      end
      begin
        for (int c = 0; c < 600 && k < 40; c++) begin
          outAcceptNewData = c[0];
          if (outAcceptNewData && outDataValid) begin
            chk("t5 data", 32'(outData), 32'(8'(8'h30 + k)));
            chk("t5 last", 32'(outIsLastByte), 32'(k % 2));
            k++;
          end
          tick();
        end
        outAcceptNewData = 1'b0;
      end
    join
    repeat (3) tick();
    chk("t5 byte total", k, 40);
    chk("t5 dropped", 32'(droppedCount), 32'h0);
    chk("t5 pktCount", 32'(packetCount), 32'h0);
    chk("t5 drained", 32'(outDataValid), 32'h0);

    // Reset mid-packet with a committed packet queued
    send_byte(8'h77, 1'b1, 1'b1);
    repeat (2) tick();
    chk("t6 queued vld", 32'(outDataValid), 32'h1);
    chk("t6 queued data", 32'(outData), 32'h77);
    send_byte(8'hE1, 1'b0, 1'b1);
    send_byte(8'hE2, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    check_all_zero("t6 reset");
    rst = 1'b0;
    chk("t6 first cycle accept", 32'(rxAcceptNewData), 32'h0);
    tick();
    chk("t6 accept back", 32'(rxAcceptNewData), 32'h1);
    send_byte(8'hD2, 1'b1, 1'b1);
    read_byte("t6 single", 8'hD2, 1'b1);
    chk("t6 dropped", 32'(droppedCount), 32'h0);
    repeat (3) tick();
    chk("t6 nothing more", 32'(outDataValid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/usb_rx_packet_buffer.md
Name: usb_rx_packet_buffer

Overview:
Packet-aware receive buffer between the SIE receive interface and the protocol engine. It stores incoming bytes speculatively and commits a packet only when its last byte arrives with keepPacket=1. Otherwise it rolls back, so the consumer only ever sees complete, error-free packets. It is parametrised in byte depth and number of queued packets, and it decouples PE read timing from SIE receive timing.

Parameters:
DEPTH, 64, byte storage entries; power of two, at least 8
MAX_PACKETS, 4, committed packets queued at once; power of two, at least 2
CNT_W, 8, width of the saturating dropped-packet counter

Ports:
clk48  in  1  system clock
rst  in  1  synchronous active-high reset
rxAcceptNewData  out  1  buffer can take a byte from the SIE
rxData  in  8  received byte
rxIsLastByte  in  1  current byte ends the packet
rxDataValid  in  1  rxData is valid and new
keepPacket  in  1  sampled with the last byte; 1 = packet good
outData  out  8  byte of the oldest committed packet
outDataValid  out  1  outData is valid
outIsLastByte  out  1  outData is the final byte of its packet
outAcceptNewData  in  1  consumer takes outData this cycle
packetCount  out  $clog2(MAX_PACKETS)+1  committed packets not yet fully read
droppedCount  out  CNT_W  packets discarded (bad, overflow or queue full); saturating

Behaviour:
- Single clock domain: clk48. Reset is synchronous and active-high on rst.
- Reset:
  - All pointers, counters and flags go to 0.
  - rxAcceptNewData=0, outDataValid=0, outIsLastByte=0, outData=0, packetCount=0, droppedCount=0.
  - Reset mid-packet loses the partial packet and all queued packets. It does not increment droppedCount.
- rxAcceptNewData=1 in every cycle after the first post-reset cycle. Overflow is handled by dropping, never by back-pressure.
- Write handshake: a byte transfers when rxDataValid && rxAcceptNewData.
- Write pointers:
  - wrPtr is the speculative write pointer; cmtPtr is the committed write pointer. Each is $clog2(DEPTH)+1 bits and wraps modulo 2*DEPTH.
  - Free space = DEPTH - (wrPtr - rdPtr), computed from the registered values at the start of the cycle. Space freed by a read in the same cycle is not visible to a write until the next cycle.
- Write states RX_IDLE / RX_STORE / RX_DISCARD:
  - RX_IDLE: the first accepted byte goes to RX_STORE, or to RX_DISCARD if the buffer is full.
  - RX_STORE: each accepted byte is written at wrPtr and wrPtr increments. A byte arriving with free space 0 moves the machine to RX_DISCARD and is not written.
  - RX_DISCARD: accepted bytes are ignored.
- Last byte (rxIsLastByte on a handshake), from any state:
  - Commit when keepPacket=1, state is not RX_DISCARD, and the length queue is not full. Then cmtPtr <= wrPtr+1 (this last byte is included) and the length is pushed.
  - Otherwise wrPtr <= cmtPtr and droppedCount increments, saturating at 2^CNT_W-1.
  - In both cases the machine returns to RX_IDLE.
- Packet length: a single-byte packet is legal. Lengths are stored as $clog2(DEPTH)+1 bits, so a packet of exactly DEPTH bytes is legal.
- Read side:
  - First-word-fall-through presentation.
  - After a commit on cycle N into an empty buffer, outDataValid=1 on cycle N+2.
  - A transfer happens when outDataValid && outAcceptNewData. The next byte is presented the following cycle with no bubbles while data is committed.
- outIsLastByte=1 exactly when the remaining byte count of the current packet is 1.
  - On that transfer the length queue pops and packetCount decrements.
  - The next packet's first byte follows on the next cycle if one is queued.
- Bytes not yet committed are never visible on the read side.
- Simultaneous commit and last-byte read: packetCount is unchanged; both queue operations take effect.
- outData, outIsLastByte and outDataValid are stable while outDataValid=1 and outAcceptNewData=0.

Decomposition:
- Package usb_buffer_pkg holds:
  - rx_state_t (RX_IDLE, RX_STORE, RX_DISCARD).
  - Pointer and length width helper functions.
- One sub-module: usb_pkt_len_fifo, a synchronous FIFO of MAX_PACKETS packet lengths.
  - Ports: push, pop, full, empty, count.
- Byte storage is an inferred dual-port RAM inside usb_rx_packet_buffer.

Test Plan:
- Single good packet: 3 bytes 0xC3,0x11,0x22 with keepPacket=1 -> outputs 0xC3,0x11,0x22, outIsLastByte only on 0x22, outDataValid rises 2 cycles after the commit, packetCount goes 1 then 0.
- Bad packet rollback: 5 bytes with keepPacket=0, then a good packet 0x69,0x05 -> only 0x69,0x05 appear, droppedCount=1.
- Overflow with DEPTH=8: a 10-byte good packet -> nothing output, droppedCount=1. A following 8-byte packet -> all 8 bytes output, last flag on byte 8.
- Queue full with MAX_PACKETS=4 and outAcceptNewData=0: 5 one-byte packets -> packetCount=4, droppedCount=1. Then drain -> the first 4 bytes in order.
- Concurrent read and write: stream 20 two-byte packets while the consumer toggles outAcceptNewData 1/0 -> all 40 bytes in order, droppedCount=0, commit and pop in the same cycle counted correctly.
- Reset mid-packet: rst asserted after byte 2 of 4 -> all outputs 0 the next cycle. A subsequent 1-byte packet 0xD2 -> output 0xD2 with outIsLastByte=1.
